// File: rtl/fetch_redirect_ctrl.sv
// Instruction fetch controller. It issues one fetch at a time, buffers the returned word
// for IF/ID, and redirects the fetch stream when the branch unit resolves a taken branch.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_ex_valid,
    input  logic        i_branch,
    input  logic [31:0] i_branch_addr,
    output logic        o_flush,
    output logic        o_misalign,
    output logic        o_fetch_req,
    output logic [31:0] o_fetch_addr,
    input  logic        i_fetch_gnt,
    input  logic        i_fetch_rvalid,
    input  logic [31:0] i_fetch_rdata,
    output logic        o_if_valid,
    output logic [31:0] o_if_inst,
    output logic [31:0] o_if_pc,
    input  logic        i_id_ready
);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, DISCARD} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] addr_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        pend_q;
    logic        req_q;
    logic        hold_q;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_inc;
    logic [31:0] fetch_pc;

    // Gated by reset so flush/misalign stay quiet while the core is held in reset.
    assign redirect = i_rst_n & i_branch & i_ex_valid & ~i_stall;
    assign target   = {i_branch_addr[31:2], 2'b00};
    assign pc_inc   = pc_q + 32'd4;
    assign fetch_pc = redirect ? target : pc_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            pend_q    <= 1'b0;
            req_q     <= 1'b0;
            hold_q    <= 1'b0;
            inst_q    <= 32'h0;
            inst_pc_q <= 32'h0;
        end else begin
            if (redirect) begin
                pc_q <= target;
            end
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                    addr_q  <= fetch_pc;
                end
                // The request address stays put until granted; a redirect here only
                // marks the in-flight word as stale.
                FETCH: begin
                    if (i_fetch_gnt) begin
                        req_q   <= 1'b0;
                        pend_q  <= 1'b0;
                        state_q <= (pend_q || redirect) ? DISCARD : WAIT;
                    end else if (redirect) begin
                        pend_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (i_fetch_rvalid) begin
                        if (redirect) begin
                            state_q <= FETCH;
                            req_q   <= 1'b1;
                            addr_q  <= target;
                        end else begin
                            state_q   <= HOLD;
                            hold_q    <= 1'b1;
                            inst_q    <= i_fetch_rdata;
                            inst_pc_q <= addr_q;
                        end
                    end else if (redirect) begin
                        state_q <= DISCARD;
                    end
                end
                HOLD: begin
                    if (redirect || (i_id_ready && !i_stall)) begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                        hold_q  <= 1'b0;
                        addr_q  <= redirect ? target : pc_inc;
                        if (!redirect) begin
                            pc_q <= pc_inc;
                        end
                    end
                end
                DISCARD: begin
                    if (i_fetch_rvalid) begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                        addr_q  <= fetch_pc;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    hold_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_flush      = redirect;
    assign o_misalign   = redirect & (i_branch_addr[1:0] != 2'b00);
    assign o_fetch_req  = req_q;
    assign o_fetch_addr = addr_q;
    assign o_if_valid   = hold_q & ~redirect;
    assign o_if_inst    = inst_q;
    assign o_if_pc      = inst_pc_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios plus a randomized run checked
// against a transaction-level model of the fetch stream.
module tb_fetch_redirect_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, ex_valid, branch;
    logic [31:0] branch_addr;
    logic        flush, misalign, fetch_req;
    logic [31:0] fetch_addr;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        if_valid;
    logic [31:0] if_inst, if_pc;
    logic        id_ready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    fetch_redirect_ctrl #(.RESET_PC(RST_PC)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_ex_valid(ex_valid),
        .i_branch(branch), .i_branch_addr(branch_addr),
        .o_flush(flush), .o_misalign(misalign),
        .o_fetch_req(fetch_req), .o_fetch_addr(fetch_addr),
        .i_fetch_gnt(gnt), .i_fetch_rvalid(rvalid), .i_fetch_rdata(rdata),
        .o_if_valid(if_valid), .o_if_inst(if_inst), .o_if_pc(if_pc),
        .i_id_ready(id_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic clear_in();
        stall = 0; ex_valid = 0; branch = 0; branch_addr = 0;
        gnt = 0; rvalid = 0; rdata = 0; id_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the DUT in its first fetch cycle (request at RST_PC), at a falling edge.
    task automatic do_reset();
        clear_in();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        clear_in();
        rst_n = 0;
        ex_valid = 1; branch = 1; branch_addr = 32'h0000_0103;
        @(negedge clk); #1;
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", fetch_req); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid got=%b exp=0", if_valid); end
        checks++; if (flush !== 1'b0 || misalign !== 1'b0) begin errors++; $display("FAIL rst_flush got=%b%b exp=00", flush, misalign); end
        checks++; if (fetch_addr !== RST_PC) begin errors++; $display("FAIL rst_addr got=%h exp=%h", fetch_addr, RST_PC); end
        checks++; if (if_inst !== 32'h0 || if_pc !== 32'h0) begin errors++; $display("FAIL rst_buf got=%h/%h exp=0/0", if_inst, if_pc); end
        clear_in();
        rst_n = 1; #1;
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL idle_req got=%b exp=0", fetch_req); end
        tick(); #1;
        checks++; if (fetch_req !== 1'b1 || fetch_addr !== RST_PC) begin errors++; $display("FAIL first_req got=%b/%h exp=1/%h", fetch_req, fetch_addr, RST_PC); end
        $display("test_reset done");
    endtask

    task automatic test_sequential();
        int last = 0;
        logic [31:0] d;
        do_reset();
        id_ready = 1;
        for (int k = 0; k < 3; k++) begin
            d = $urandom;
            #1;
            checks++; if (fetch_req !== 1'b1 || fetch_addr !== 32'(4 * k)) begin errors++; $display("FAIL seq_req k=%0d got=%b/%h exp=1/%h", k, fetch_req, fetch_addr, 4 * k); end
            gnt = 1; tick(); gnt = 0; #1;
            checks++; if (fetch_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL seq_wait k=%0d got=%b/%b exp=0/0", k, fetch_req, if_valid); end
            rvalid = 1; rdata = d; tick(); rvalid = 0; #1;
            checks++; if (if_valid !== 1'b1 || if_inst !== d || if_pc !== 32'(4 * k)) begin errors++; $display("FAIL seq_hold k=%0d got=%b/%h/%h exp=1/%h/%h", k, if_valid, if_inst, if_pc, d, 4 * k); end
            if (k > 0) begin
                checks++; if (cyc - last != 3) begin errors++; $display("FAIL seq_gap k=%0d got=%0d exp=3", k, cyc - last); end
            end
            last = cyc;
            $display("txn seq pc=%h inst=%h", if_pc, if_inst);
            tick();
        end
    endtask

    task automatic test_redirect_fetch();
        do_reset();
        ex_valid = 1; branch = 1; branch_addr = 32'h0000_0100; #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rf_flush got=%b exp=1", flush); end
        tick(); branch = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h0) begin errors++; $display("FAIL rf_hold i=%0d got=%b/%h exp=1/0", i, fetch_req, fetch_addr); end
            tick();
        end
        gnt = 1; #1;
        checks++; if (fetch_addr !== 32'h0) begin errors++; $display("FAIL rf_gnt_addr got=%h exp=0", fetch_addr); end
        tick(); gnt = 0;
        rvalid = 1; rdata = 32'hDEAD_BEEF; #1;
        checks++; if (if_valid !== 1'b0 || fetch_req !== 1'b0) begin errors++; $display("FAIL rf_discard got=%b/%b exp=0/0", if_valid, fetch_req); end
        tick(); rvalid = 0; #1;
        checks++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h100 || if_valid !== 1'b0) begin errors++; $display("FAIL rf_next got=%b/%h/%b exp=1/100/0", fetch_req, fetch_addr, if_valid); end
        $display("txn redirect_fetch next=%h", fetch_addr);
    endtask

    task automatic test_redirect_wait();
        do_reset();
        gnt = 1; tick(); gnt = 0;
        ex_valid = 1; branch = 1; branch_addr = 32'h0000_0200; #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rw_flush got=%b exp=1", flush); end
        tick(); branch = 0; #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rw_flush_pulse got=%b exp=0", flush); end
        tick();
        rvalid = 1; rdata = 32'h1234_5678; #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rw_drop got=%b exp=0", if_valid); end
        tick(); rvalid = 0; #1;
        checks++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h200 || if_valid !== 1'b0) begin errors++; $display("FAIL rw_next got=%b/%h/%b exp=1/200/0", fetch_req, fetch_addr, if_valid); end
        $display("txn redirect_wait next=%h", fetch_addr);
    endtask

    task automatic test_redirect_rvalid();
        do_reset();
        gnt = 1; tick(); gnt = 0;
        ex_valid = 1; branch = 1; branch_addr = 32'h0000_0300;
        rvalid = 1; rdata = 32'hCAFE_0001;
        tick(); branch = 0; rvalid = 0; #1;
        checks++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h300 || if_valid !== 1'b0) begin errors++; $display("FAIL rr_next got=%b/%h/%b exp=1/300/0", fetch_req, fetch_addr, if_valid); end
        $display("txn redirect_rvalid next=%h", fetch_addr);
    endtask

    task automatic test_hold_redirect();
        logic [31:0] d;
        do_reset();
        gnt = 1; tick(); gnt = 0;
        rvalid = 1; rdata = 32'h0BAD_F00D; tick(); rvalid = 0;
        id_ready = 1; ex_valid = 1; branch = 1; branch_addr = 32'h0000_0402; #1;
        checks++; if (if_valid !== 1'b0 || misalign !== 1'b1 || flush !== 1'b1) begin errors++; $display("FAIL hr_same got=%b/%b/%b exp=0/1/1", if_valid, misalign, flush); end
        tick(); branch = 0; #1;
        checks++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h400) begin errors++; $display("FAIL hr_next got=%b/%h exp=1/400", fetch_req, fetch_addr); end
        d = $urandom;
        gnt = 1; tick(); gnt = 0;
        rvalid = 1; rdata = d; tick(); rvalid = 0;
        stall = 1; branch = 1; branch_addr = 32'h0000_0501; #1;
        checks++; if (flush !== 1'b0 || misalign !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h400 || if_inst !== d) begin errors++; $display("FAIL hr_stall got=%b/%b/%b/%h exp=0/0/1/400", flush, misalign, if_valid, if_pc); end
        tick(); branch = 0; #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h400) begin errors++; $display("FAIL hr_stall_hold got=%b/%h exp=1/400", if_valid, if_pc); end
        stall = 0; tick(); #1;
        checks++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h404) begin errors++; $display("FAIL hr_seq got=%b/%h exp=1/404", fetch_req, fetch_addr); end
        $display("txn hold_redirect next=%h", fetch_addr);
    endtask

    task automatic test_wrap();
        do_reset();
        ex_valid = 1; branch = 1; branch_addr = 32'hFFFF_FFFC; gnt = 1;
        tick(); branch = 0; gnt = 0;
        rvalid = 1; tick(); rvalid = 0; #1;
        checks++; if (fetch_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got=%h exp=fffffffc", fetch_addr); end
        gnt = 1; tick(); gnt = 0;
        rvalid = 1; rdata = 32'h7777_0000; tick(); rvalid = 0;
        id_ready = 1; #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_hold got=%b/%h exp=1/fffffffc", if_valid, if_pc); end
        tick(); #1;
        checks++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got=%b/%h exp=1/0", fetch_req, fetch_addr); end
        $display("txn wrap next=%h", fetch_addr);
    endtask

    task automatic test_reset_midfetch();
        do_reset();
        gnt = 1; tick(); gnt = 0;
        #1; rst_n = 0; #1;
        checks++; if (fetch_req !== 1'b0 || fetch_addr !== RST_PC || if_valid !== 1'b0) begin errors++; $display("FAIL mid_rst got=%b/%h/%b exp=0/%h/0", fetch_req, fetch_addr, if_valid, RST_PC); end
        @(negedge clk); rst_n = 1;
        rvalid = 1; rdata = 32'hBAD0_BAD0;
        tick(); #1;
        checks++; if (fetch_req !== 1'b1 || fetch_addr !== RST_PC) begin errors++; $display("FAIL mid_req got=%b/%h exp=1/%h", fetch_req, fetch_addr, RST_PC); end
        tick(); rvalid = 0; #1;
        checks++; if (fetch_req !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL mid_ignore got=%b/%b exp=1/0", fetch_req, if_valid); end
        gnt = 1; tick(); gnt = 0;
        rvalid = 1; rdata = 32'h600D_600D; tick(); rvalid = 0; #1;
        checks++; if (if_valid !== 1'b1 || if_inst !== 32'h600D_600D || if_pc !== RST_PC) begin errors++; $display("FAIL mid_data got=%b/%h/%h exp=1/600d600d/%h", if_valid, if_inst, if_pc, RST_PC); end
        $display("txn reset_midfetch inst=%h", if_inst);
    endtask

    // Model tracks the fetch stream as transactions: an open request, an outstanding
    // response (possibly stale), or a presented instruction, plus the next fetch PC.
    task automatic test_random(input int n);
        bit          m_req, m_dead, m_wait, m_wdead, m_hold, redir;
        logic [31:0] m_pc, m_raddr, m_hinst, m_hpc, t;
        int          rcnt;
        do_reset();
        m_req = 1; m_dead = 0; m_wait = 0; m_wdead = 0; m_hold = 0;
        m_pc = RST_PC; m_raddr = RST_PC; m_hinst = 0; m_hpc = 0; rcnt = 0;
        for (int c = 0; c < n; c++) begin
            stall       = ($urandom % 5 == 0);
            ex_valid    = ($urandom % 6 != 0);
            branch      = ($urandom % 6 == 0);
            branch_addr = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : ($urandom % 4096);
            gnt         = ($urandom % 3 != 0);
            id_ready    = ($urandom % 4 != 0);
            rdata       = $urandom;
            rvalid      = (m_wait && rcnt == 0) || ((m_req || m_hold) && ($urandom % 16 == 0));
            #1;
            redir = branch & ex_valid & ~stall;
            t = {branch_addr[31:2], 2'b00};
            checks++; if (fetch_req !== m_req) begin errors++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, fetch_req, m_req); end
            if (m_req) begin
                checks++; if (fetch_addr !== m_raddr) begin errors++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, fetch_addr, m_raddr); end
            end
            checks++; if (flush !== redir) begin errors++; $display("FAIL rnd_flush c=%0d got=%b exp=%b", c, flush, redir); end
            checks++; if (misalign !== (redir && branch_addr[1:0] != 2'b00)) begin errors++; $display("FAIL rnd_misalign c=%0d got=%b", c, misalign); end
            checks++; if (if_valid !== (m_hold && !redir)) begin errors++; $display("FAIL rnd_if_valid c=%0d got=%b exp=%b", c, if_valid, m_hold && !redir); end
            if (m_hold && !redir) begin
                checks++; if (if_inst !== m_hinst || if_pc !== m_hpc) begin errors++; $display("FAIL rnd_inst c=%0d got=%h/%h exp=%h/%h", c, if_inst, if_pc, m_hinst, m_hpc); end
                if (id_ready && !stall) $display("txn rnd pc=%h inst=%h", m_hpc, m_hinst);
            end
            if (m_req) begin
                if (redir) m_pc = t;
                if (gnt) begin
                    m_req = 0; m_wait = 1; m_wdead = m_dead | redir;
                    rcnt = $urandom_range(0, 2);
                end else begin
                    m_dead = m_dead | redir;
                end
            end else if (m_wait) begin
                if (redir) m_pc = t;
                if (rvalid) begin
                    m_wait = 0;
                    if (redir || m_wdead) begin
                        m_req = 1; m_raddr = m_pc; m_dead = 0;
                    end else begin
                        m_hold = 1; m_hinst = rdata; m_hpc = m_raddr;
                    end
                end else begin
                    if (redir) m_wdead = 1;
                    if (rcnt > 0) rcnt--;
                end
            end else if (m_hold) begin
                if (redir || (id_ready && !stall)) begin
                    m_hold = 0;
                    m_pc = redir ? t : m_hpc + 32'd4;
                    m_req = 1; m_raddr = m_pc; m_dead = 0;
                end
            end
            tick();
        end
    endtask

    initial begin
        clear_in();
        rst_n = 0;
        test_reset();
        test_sequential();
        test_redirect_fetch();
        test_redirect_wait();
        test_redirect_rvalid();
        test_hold_redirect();
        test_wrap();
        test_reset_midfetch();
        test_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
  RESET_PC  32'h0000_0000  first fetch address after reset
REQ-002 Ports SHALL be, one per line:
  i_clk  in  1  single clock, rising edge
  i_rst_n  in  1  asynchronous, active-low reset
  i_stall  in  1  pipeline stall; EX stage frozen
  i_ex_valid  in  1  EX stage holds a valid instruction
  i_branch  in  1  branch/jump taken, from branch unit
  i_branch_addr  in  32  redirect target, from branch unit
  o_flush  out  1  flush IF/ID and ID/EX this cycle
  o_misalign  out  1  one-cycle pulse, redirect target bits[1:0] nonzero
  o_fetch_req  out  1  fetch address valid (read-address valid)
  o_fetch_addr  out  32  fetch address
  i_fetch_gnt  in  1  fetch address accepted (read-address ready)
  i_fetch_rvalid  in  1  fetch data valid; always accepted
  i_fetch_rdata  in  32  fetch data
  o_if_valid  out  1  instruction presented to IF/ID
  o_if_inst  out  32  instruction word
  o_if_pc  out  32  PC of o_if_inst
  i_id_ready  in  1  IF/ID accepts instruction

Function
REQ-003 Clock is i_clk only; reset is asynchronous, active-low on i_rst_n, as fixed for this block.
REQ-004 States: IDLE, FETCH, WAIT, HOLD, DISCARD; at most one fetch outstanding.
REQ-005 Redirect event: i_branch & i_ex_valid & ~i_stall; i_branch while i_stall or ~i_ex_valid ignored.
REQ-006 o_flush = redirect event, combinational, same cycle.
REQ-007 Redirect target = {i_branch_addr[31:2], 2'b00}; o_misalign = redirect event & (i_branch_addr[1:0] != 0).
REQ-008 IDLE: entered only by reset; o_fetch_req=0; unconditionally -> FETCH next cycle.
REQ-009 FETCH: o_fetch_req=1, o_fetch_addr=req_addr; req_addr and o_fetch_req SHALL hold stable until i_fetch_gnt.
REQ-010 FETCH, gnt, no pending redirect -> WAIT; gnt with pending redirect (or redirect this cycle) -> DISCARD.
REQ-011 FETCH, redirect without gnt: pc <= target, redirect-pending set, address not changed; on gnt -> DISCARD.
REQ-012 WAIT: i_fetch_rvalid -> capture rdata and req_addr into buffer, -> HOLD; redirect without rvalid -> pc <= target, -> DISCARD; redirect with rvalid -> data dropped, pc <= target, -> FETCH.
REQ-013 HOLD: o_if_valid=1, o_if_inst/o_if_pc from buffer; i_id_ready & ~i_stall -> pc <= pc+4, -> FETCH.
REQ-014 HOLD, redirect -> buffer invalidated, o_if_valid=0 same cycle, pc <= target, -> FETCH; redirect wins over simultaneous acceptance.
REQ-015 DISCARD: response dropped, never presented; rvalid -> FETCH at pc; further redirect updates pc, state unchanged.
REQ-016 o_if_valid=0 in all states except HOLD.
REQ-017 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-018 Normal throughput: one instruction per 3 cycles minimum (FETCH, WAIT, HOLD) with gnt/rvalid zero-wait.
REQ-019 i_fetch_rvalid in IDLE, FETCH or HOLD is a protocol error; ignored, no state change.

Reset
REQ-020 While i_rst_n=0: state IDLE, pc=RESET_PC, redirect-pending=0, buffer invalid, o_fetch_req=0, o_if_valid=0, o_flush=0, o_misalign=0, o_fetch_addr=RESET_PC, o_if_inst=0, o_if_pc=0.
REQ-021 Reset mid-fetch SHALL abandon the outstanding transaction; response arriving after reset release before first gnt ignored per REQ-019.

Verification
REQ-022 Reset release, gnt and rvalid each 1 cycle after request, id_ready=1 -> fetches at 0x0, 0x4, 0x8, each o_if_valid 3 cycles apart.
REQ-023 Redirect to 0x100 in FETCH with gnt held low 3 cycles -> o_fetch_addr stays old value until gnt, response dropped, next request 0x100.
REQ-024 Redirect to 0x200 in WAIT, rvalid 2 cycles later -> o_flush 1 cycle, rdata never on o_if_valid, next request 0x200.
REQ-025 Redirect to 0x300 same cycle as rvalid in WAIT -> no DISCARD, next cycle FETCH 0x300.
REQ-026 HOLD with i_id_ready=1 and redirect to 0x402 same cycle -> o_if_valid=0, o_misalign=1, next request 0x400; redirect with i_stall=1 -> no flush.
REQ-027 pc=0xFFFF_FFFC instruction accepted -> next request 0x0000_0000.
